// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_entry_t : one prefetch queue entry {pc, instr, fault}
//   fetch_state_t : fetch state machine encoding
//   NOP_INSTR     : instruction substituted for faulted fetches and idle output
//   PC_STEP       : sequential fetch increment (one 32-bit word)
package imem_fetch_ctrl_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN     = 1'b0,
        FETCH_FAULTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'h0000_0004;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Small FIFO of fetch entries between the fetch stage and decode.
// Ports:
//   clock, reset     : clock and asynchronous active-high reset
//   push, push_entry : enqueue request and data (ignored when full unless popping)
//   pop              : dequeue the head (ignored when empty)
//   flush            : synchronous clear of both pointers, overrides push/pop
//   full, empty      : occupancy status
//   head             : entry at the read pointer (meaningful only when !empty)
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits match.
module imem_fetch_ctrl_fetch_queue
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    fetch_entry_t store_r [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = store_r[rd_ptr_r[AW-1:0]];

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && !empty;
            do_push_s = push && (!full || do_pop_s);
        end
    end

    // Read/write pointer update; flush empties the queue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; cleared on reset so the head never exposes stale data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= '{pc: 32'h0000_0000, instr: NOP_INSTR, fault: 1'b0};
            end
        end else if (do_push_s) begin
            store_r[wr_ptr_r[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller for the CPU front end.
// Holds the fetch PC, addresses the combinational instruction memory every
// cycle, and queues {pc, instr, fault} entries for decode.
// Ports:
//   clock, reset               : clock and asynchronous active-high reset
//   imem_address               : memory address, always equal to the fetch PC
//   imem_data, imem_valid      : same-cycle memory response (valid = aligned hit)
//   halt                       : suppress new fetches; queue keeps draining
//   redirect_valid/redirect_pc : flush queue and restart fetch at redirect_pc
//   out_valid/out_ready        : decode handshake on the queue head
//   out_pc/out_instr/out_fault : head entry (reset values when empty)
//   busy                       : fetching and not halted
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic        busy
);

    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic         push_s;
    logic         pop_s;
    logic         q_full_s;
    logic         q_empty_s;
    fetch_entry_t q_head_s;
    fetch_entry_t push_entry_s;

    imem_fetch_ctrl_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .push_entry (push_entry_s),
        .full       (q_full_s),
        .empty      (q_empty_s),
        .head       (q_head_s)
    );

    assign imem_address = pc_r;

    // Handshake and push decision; a redirect cycle neither pushes nor pops.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        push_entry_s = '{pc: pc_r, instr: NOP_INSTR, fault: 1'b1};
        if (redirect_valid) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = !q_empty_s && out_ready;
            push_s = (state_r == FETCH_RUN) && !halt && (!q_full_s || pop_s);
        end
        if (imem_valid) begin
            push_entry_s = '{pc: pc_r, instr: imem_data, fault: 1'b0};
        end else begin
            push_entry_s = '{pc: pc_r, instr: NOP_INSTR, fault: 1'b1};
        end
    end

    // Next PC and fetch state; a miss parks the PC on the faulting address.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        if (redirect_valid) begin
            pc_next_s    = redirect_pc;
            state_next_s = FETCH_RUN;
        end else begin
            case (state_r)
                FETCH_RUN: begin
                    if (push_s && imem_valid) begin
                        pc_next_s = pc_r + PC_STEP;
                    end else if (push_s) begin
                        state_next_s = FETCH_FAULTED;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
                FETCH_FAULTED: begin
                    state_next_s = FETCH_FAULTED;
                end
                default: begin
                    state_next_s = FETCH_FAULTED;
                end
            endcase
        end
    end

    // PC and state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            state_r <= FETCH_RUN;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
        end
    end

    // Present the queue head, falling back to idle values when empty.
    always_comb begin
        out_valid = !q_empty_s;
        out_pc    = 32'h0000_0000;
        out_instr = NOP_INSTR;
        out_fault = 1'b0;
        if (!q_empty_s) begin
            out_pc    = q_head_s.pc;
            out_instr = q_head_s.instr;
            out_fault = q_head_s.fault;
        end else begin
            out_pc    = 32'h0000_0000;
            out_instr = NOP_INSTR;
            out_fault = 1'b0;
        end
    end

    // busy is forced low while reset is held, whatever the halt input does.
    assign busy = (state_r == FETCH_RUN) && !halt && !reset;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] MEM_BYTES = 32'h0001_0000;
    localparam int          MEM_WORDS = 16384;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    imem_fetch_ctrl #(
        .RESET_PC    (BASE),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Instruction memory: 16384 words at BASE, hit only when aligned and in range.
    logic [31:0] mem [MEM_WORDS];

    function automatic logic hit(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + MEM_BYTES);
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return mem[off[15:2]];
    endfunction

    assign imem_valid = hit(imem_address);
    assign imem_data  = imem_valid ? word(imem_address) : 32'hDEAD_BEEF;

    // Reference model: list of queued entries, fetch PC, fault-stop flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mfaulted;

    task automatic model_reset();
        mq.delete();
        mpc = BASE;
        mfaulted = 0;
    endtask

    // Apply the current inputs to the model, then advance the DUT one clock.
    task automatic step();
        bit do_pop;
        bit do_push;
        do_pop = (mq.size() > 0) && out_ready;
        if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
            mfaulted = 0;
        end else begin
            do_push = !mfaulted && !halt && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) mq.delete(0);
            if (do_push) begin
                if (hit(mpc)) begin
                    mq.push_back('{pc: mpc, instr: word(mpc), fault: 1'b0});
                    mpc = mpc + 32'd4;
                end else begin
                    mq.push_back('{pc: mpc, instr: NOP, fault: 1'b1});
                    mfaulted = 1;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [98:0] exp_vec();
        ent_t h;
        if (mq.size() > 0) h = mq[0];
        else h = '{pc: 32'h0, instr: NOP, fault: 1'b0};
        return {mq.size() > 0, h.pc, h.instr, h.fault, mpc, !mfaulted && !halt};
    endfunction

    function automatic logic [98:0] obs_vec();
        return {out_valid, out_pc, out_instr, out_fault, imem_address, busy};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({out_valid, out_pc, out_instr, out_fault, imem_address, busy} !==
            {1'b0, 32'h0, NOP, 1'b0, BASE, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_values got=%h exp=%h", obs_vec(),
                     {1'b0, 32'h0, NOP, 1'b0, BASE, 1'b0});
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        out_ready = 1'b1;
        step();
        compared++;
        if (!out_valid || out_pc !== BASE) begin
            mismatched++;
            $display("FAIL first_fetch got valid=%b pc=%h exp valid=1 pc=%h", out_valid, out_pc, BASE);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        compared++;
        if (imem_address !== 32'h8000_0008) begin
            mismatched++;
            $display("FAIL stall_address got=%h exp=%h", imem_address, 32'h8000_0008);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL drain cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        compared++;
        if (obs_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL redirect_flush got=%h exp=%h", obs_vec(), exp_vec());
        end
        step();
        compared++;
        if (!out_valid || out_pc !== 32'h8000_0100) begin
            mismatched++;
            $display("FAIL redirect_target got valid=%b pc=%h exp valid=1 pc=80000100", out_valid, out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL redirect_after cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_end_of_memory();
        bit seen_fault;
        seen_fault = 0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_FFF0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid && out_fault && out_pc == 32'h8001_0000 && out_instr == NOP) seen_fault = 1;
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL end_of_mem cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        compared++;
        if (!seen_fault || busy !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_stop got seen=%b busy=%b valid=%b exp seen=1 busy=0 valid=0",
                     seen_fault, busy, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = BASE;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL resume cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        step();
        compared++;
        if ({out_valid, out_pc, out_instr, out_fault, busy} !== {1'b1, 32'h8000_0102, NOP, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL misaligned got v=%b pc=%h i=%h f=%b busy=%b exp v=1 pc=80000102 i=00000013 f=1 busy=0",
                     out_valid, out_pc, out_instr, out_fault, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL misaligned_after cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        halt = 1'b1;
        frozen = mpc;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec() || imem_address !== frozen) begin
                mismatched++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL halt_drained got valid=%b exp valid=0", out_valid);
        end
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL unhalt cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        step();
        step();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset got valid=%b busy=%b exp valid=0 busy=0", out_valid, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = BASE + {16'h0, $urandom_range(0, 16383) << 2};
                1: redirect_pc = 32'h8000_FFE0 + ($urandom_range(0, 7) << 2);
                2: redirect_pc = BASE + 32'h0000_0100 + $urandom_range(1, 3);
                default: redirect_pc = 32'h0000_1000;
            endcase
            step();
            compared++;
            if (obs_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_memory();
        test_misaligned();
        test_halt();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the combinational instruction memory for the CPU front end.
- Holds the fetch PC and drives the memory address every cycle.
- Captures {pc, instr, fault} into a small prefetch queue and presents it to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap), halt, and out-of-range/misaligned fetch faults.

Parameters:
- RESET_PC, 32'h8000_0000: PC loaded on reset; matches the instruction memory base address.
- QUEUE_DEPTH, 2: prefetch queue entries; power of two, ≥ 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_address  output  32  address to the instruction memory; equals fetch PC.
- imem_data  input  32  instruction word from memory, same cycle.
- imem_valid  input  1  memory hit (aligned and in range), same cycle.
- halt  input  1  stop issuing new fetches; the queue still drains.
- redirect_valid  input  1  load a new PC and flush the queue.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts the head.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_fault  output  1  head entry is a fetch fault; out_instr is 32'h0000_0013.
- busy  output  1  state is RUN and not halted.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = RESET_PC, queue empty, state = RUN.
  - out_valid = 0, out_pc = 0, out_instr = 32'h0000_0013, out_fault = 0, busy = 0 while reset is high.
- imem_address = pc at all times; this is purely combinational.
- States:
  - RUN: fetching.
  - FAULTED: fetch stopped after a fault entry was queued.
- Fetch push condition: state == RUN && !halt && !redirect_valid && (queue not full || pop this cycle).
- On push:
  - Enqueue {pc, imem_valid ? imem_data : 32'h13, !imem_valid}.
  - If imem_valid, pc <= pc + 4 (32-bit wrap, no saturation).
  - If !imem_valid, pc holds and state <= FAULTED. No further pushes until a redirect.
- Pop condition: out_valid && out_ready. Head advances at the clock edge.
- Push and pop in the same cycle when full is allowed; the count is unchanged.
- Redirect has priority over everything:
  - At the edge: queue flushed (count = 0), pc <= redirect_pc, state <= RUN.
  - A pop in the same cycle is discarded.
  - No push occurs in the redirect cycle.
- Latency:
  - Fetch to out_valid is 1 cycle (entry visible the cycle after push).
  - Redirect in cycle N: target fetched in N+1, out_valid with target in N+2.
  - Back-to-back throughput is 1 instr/cycle with out_ready held high.
- halt:
  - Only suppresses pushes; pc holds.
  - Deassertion resumes fetching the next cycle.
  - Redirect during halt still loads pc.
- A misaligned redirect_pc is not checked locally; the memory reports imem_valid = 0, which produces a fault entry.
- Queue full with no pop: pc holds; the memory is re-read next cycle (combinational, no side effects).
- out_* reflect the queue head; when empty they hold the reset values (out_instr = NOP).
- busy = (state == RUN) && !halt.
- Reset mid-operation discards all entries immediately, including combinationally on out_valid.

Decomposition:
- Package pack:
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic fault;} fetch_entry_t.
  - typedef enum logic {FETCH_RUN, FETCH_FAULTED} fetch_state_t.
  - localparam logic [31:0] NOP_INSTR = 32'h0000_0013.
- Sub-module fetch_queue:
  - Parameterised FIFO of fetch_entry_t with DEPTH.
  - Ports: push/pop/flush, full/empty, head.
  - Pointer wrap uses $clog2(DEPTH) + 1-bit pointers; flush resets both pointers.
- The top level holds pc, the state machine and the push/pop logic.

Test Plan:
- Reset release, memory model loaded, out_ready = 1 → cycle 1: out_valid = 1, out_pc = 8000_0000. Subsequent cycles give out_pc 8000_0004, 8000_0008, …, one per cycle with no bubbles.
- out_ready = 0 for 5 cycles after reset → queue fills with 8000_0000 and 8000_0004; imem_address stalls at 8000_0008. Raising out_ready drains in order with no loss or duplicates.
- Redirect to 8000_0100 while queue holds 2 entries and out_ready = 1 → old entries never accepted; two cycles later out_pc = 8000_0100.
- Fetch runs to the last word (8000_FFFC at 16384 words), then 8001_0000 → entry with out_fault = 1, out_instr = 0000_0013, out_pc = 8001_0000. Afterwards no pushes and busy = 0 until redirect_valid to 8000_0000 resumes.
- Redirect to 8000_0102 (misaligned) → single fault entry with out_pc = 8000_0102, state FAULTED.
- halt = 1 for 3 cycles mid-stream → pc frozen, queue drains to out_valid = 0. Deassert → fetch resumes at the frozen pc. Assert reset asynchronously mid-stream → out_valid drops immediately, pc = 8000_0000 after release.
